// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, R-type functs, ALU selects, mult/div FSM states.
// No logic of its own; zero latency.
// No flow control.
package ex_pkg;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_AND   = 3'b010;
    localparam logic [2:0] ALU_OP_OR    = 3'b011;
    localparam logic [2:0] ALU_OP_XOR   = 3'b100;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b101;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // Divide by zero: LO is filled with this bit, HI returns the dividend.
    localparam logic DIVZ_LO_FILL = 1'b1;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MFHI, ALU_MFLO, ALU_MULDIV
    } alu_sel_t;

    typedef enum logic [1:0] {
        MD_IDLE, MD_RUN, MD_DONE
    } md_state_t;

    function automatic alu_sel_t decode_funct(input logic [5:0] f);
        case (f)
            F_ADD:  return ALU_ADD;
            F_SUB:  return ALU_SUB;
            F_AND:  return ALU_AND;
            F_OR:   return ALU_OR;
            F_XOR:  return ALU_XOR;
            F_MFHI: return ALU_MFHI;
            F_MFLO: return ALU_MFLO;
            F_MULT, F_MULTU, F_DIV, F_DIVU: return ALU_MULDIV;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative mult/div (shift-add / restoring, one bit per cycle) holding architectural HI/LO.
// Latency: XLEN+1 stalled cycles from start; HI/LO valid in the DONE cycle.
// Backpressure: stall is raised combinationally on start and held through RUN.
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN + 1);

    md_state_t         state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   d_q, a_q, a_mag, b_mag, hi_nxt, lo_nxt;
    logic [XLEN:0]     sum, trial;
    logic [1:0]        op_q;
    logic              a_neg, b_neg, q_neg, r_neg, b_zero;

    // op[0]=1 selects the unsigned variant, op[1]=1 selects divide.
    assign a_neg = ~op[0] & a[XLEN-1];
    assign b_neg = ~op[0] & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        sum     = '0;
        trial   = '0;
        acc_nxt = acc;
        if (op_q[1]) begin
            trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, d_q};
            if (!trial[XLEN])
                acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, d_q} : '0);
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_fix = q_neg ? -acc_nxt : acc_nxt;
        hi_nxt   = prod_fix[2*XLEN-1:XLEN];
        lo_nxt   = prod_fix[XLEN-1:0];
        if (op_q[1]) begin
            if (b_zero) begin
                hi_nxt = a_q;
                lo_nxt = {XLEN{DIVZ_LO_FILL}};
            end else begin
                // min_int / -1 falls out naturally: |min_int| negated is min_int, remainder 0.
                hi_nxt = r_neg ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
                lo_nxt = q_neg ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            d_q    <= '0;
            a_q    <= '0;
            op_q   <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= a;
                        q_neg  <= a_neg ^ b_neg;
                        r_neg  <= a_neg;
                        b_zero <= (b == '0);
                        acc    <= {{XLEN{1'b0}}, op[1] ? a_mag : b_mag};
                        d_q    <= op[1] ? b_mag : a_mag;
                        cnt    <= CW'(XLEN);
                        state  <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi    <= hi_nxt;
                        lo    <= lo_nxt;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign stall = ((state == MD_IDLE) && start) || (state == MD_RUN);
    assign busy  = (state != MD_IDLE);

endmodule

// File: rtl/ex_stage_md.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, mfhi/mflo, iterative mult/div.
// Latency: ALU/mfhi/mflo combinational; mult/div holds stall for XLEN+1 cycles.
// Backpressure: stall freezes PC, IF/ID and ID/EX while a mult/div runs.
module ex_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [XLEN-1:0] read_data_1,
    input  logic [XLEN-1:0] read_data_2,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] EX_MEM_alu_result,
    input  logic [XLEN-1:0] MEM_WB_wb_data,
    input  logic [XLEN-1:0] imm,
    input  logic [2:0]      alu_op,
    input  logic            alu_src,
    input  logic            reg_dst,
    input  logic [RAW-1:0]  rt,
    input  logic [RAW-1:0]  rd,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data,
    output logic [RAW-1:0]  write_reg,
    output logic            stall,
    output logic            busy
);
    logic [XLEN-1:0] op_a, op_b, alu_in_b, hi, lo;
    alu_sel_t        sel;
    logic            md_start;

    always_comb begin
        case (forwardA)
            2'b10:   op_a = EX_MEM_alu_result;
            2'b01:   op_a = MEM_WB_wb_data;
            default: op_a = read_data_1;
        endcase
        case (forwardB)
            2'b10:   op_b = EX_MEM_alu_result;
            2'b01:   op_b = MEM_WB_wb_data;
            default: op_b = read_data_2;
        endcase
    end

    assign alu_in_b   = alu_src ? imm : op_b;
    assign write_data = op_b;

    always_comb begin
        case (alu_op)
            ALU_OP_SUB:   sel = ALU_SUB;
            ALU_OP_AND:   sel = ALU_AND;
            ALU_OP_OR:    sel = ALU_OR;
            ALU_OP_XOR:   sel = ALU_XOR;
            ALU_OP_RTYPE: sel = decode_funct(imm[5:0]);
            default:      sel = ALU_ADD;
        endcase
    end

    always_comb begin
        case (sel)
            ALU_SUB:    alu_result = op_a - alu_in_b;
            ALU_AND:    alu_result = op_a & alu_in_b;
            ALU_OR:     alu_result = op_a | alu_in_b;
            ALU_XOR:    alu_result = op_a ^ alu_in_b;
            ALU_MFHI:   alu_result = hi;
            ALU_MFLO:   alu_result = lo;
            ALU_MULDIV: alu_result = '0;
            default:    alu_result = op_a + alu_in_b;
        endcase
    end

    // mult/div never writes a GPR; the result lives in HI/LO.
    assign write_reg = (sel == ALU_MULDIV) ? '0 : (reg_dst ? rd : rt);
    assign md_start  = valid_in && (sel == ALU_MULDIV);

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (imm[1:0]),
        .a     (op_a),
        .b     (op_b),
        .stall (stall),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

endmodule
